// File: rtl/bu_pipe.sv
// Pipelined branch unit: evaluates one of eight compare conditions, computes the
// branch target / redirect PC, flags mispredicts and keeps saturating perf counters.
module bu_pipe #(
  parameter int WIDTH  = 32,
  parameter int PC_W   = 32,
  parameter int OFF_W  = 16,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [2:0]       func,
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // producer holding valid keeps its payload stable until ready is seen.

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("bu_pipe: STAGES must be 1 or 2");
  end

  logic             r_out_valid;
  logic             r_taken;
  logic [PC_W-1:0]  r_target;
  logic [PC_W-1:0]  r_redirect;
  logic             r_mis;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mis_count;

  logic             w_adv_out;
  logic             w_s_valid;
  logic [WIDTH-1:0] w_s_in0;
  logic [WIDTH-1:0] w_s_in1;
  logic [2:0]       w_s_func;
  logic [PC_W-1:0]  w_s_pc;
  logic [OFF_W-1:0] w_s_offset;
  logic             w_s_pred;

  assign w_adv_out = !r_out_valid || out_ready;

  if (STAGES == 2) begin : g_two
    logic             r_a_valid;
    logic [WIDTH-1:0] r_a_in0;
    logic [WIDTH-1:0] r_a_in1;
    logic [2:0]       r_a_func;
    logic [PC_W-1:0]  r_a_pc;
    logic [OFF_W-1:0] r_a_offset;
    logic             r_a_pred;
    logic             w_adv_a;

    assign w_adv_a  = !r_a_valid || w_adv_out;
    assign in_ready = !flush && w_adv_a;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_a_valid <= 1'b0;
      end else if (flush) begin
        r_a_valid <= 1'b0;
      end else if (w_adv_a) begin
        r_a_valid <= in_valid;
      end
    end

    // Payload registers carry no reset; they are only observed behind r_a_valid.
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
        r_a_in0    <= in0;
        r_a_in1    <= in1;
        r_a_func   <= func;
        r_a_pc     <= pc;
        r_a_offset <= offset;
        r_a_pred   <= pred_taken;
      end
    end

    assign w_s_valid  = r_a_valid;
    assign w_s_in0    = r_a_in0;
    assign w_s_in1    = r_a_in1;
    assign w_s_func   = r_a_func;
    assign w_s_pc     = r_a_pc;
    assign w_s_offset = r_a_offset;
    assign w_s_pred   = r_a_pred;
  end else begin : g_one
    assign in_ready   = !flush && w_adv_out;
    assign w_s_valid  = in_valid;
    assign w_s_in0    = in0;
    assign w_s_in1    = in1;
    assign w_s_func   = func;
    assign w_s_pc     = pc;
    assign w_s_offset = offset;
    assign w_s_pred   = pred_taken;
  end

  logic            w_eq;
  logic            w_lt_u;
  logic            w_lt_s;
  logic            w_gt_s;
  logic            w_taken;
  logic [PC_W-1:0] w_off_ext;
  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_redirect;

  assign w_eq   = (w_s_in0 == w_s_in1);
  assign w_lt_u = (w_s_in0 < w_s_in1);
  assign w_lt_s = ($signed(w_s_in0) < $signed(w_s_in1));
  assign w_gt_s = ($signed(w_s_in0) > $signed(w_s_in1));

  always_comb begin
    w_taken = 1'b0;
    case (w_s_func)
      3'd0:    w_taken = w_eq;
      3'd1:    w_taken = !w_eq;
      3'd2:    w_taken = !w_gt_s;
      3'd3:    w_taken = w_gt_s;
      3'd4:    w_taken = w_lt_u;
      3'd5:    w_taken = !w_lt_u;
      3'd6:    w_taken = w_lt_s;
      default: w_taken = !w_lt_s;
    endcase
  end

  // Offset counts words; sums wrap naturally at PC_W bits.
  assign w_off_ext  = PC_W'($signed(w_s_offset));
  assign w_seq_pc   = w_s_pc + PC_W'(4);
  assign w_target   = w_seq_pc + (w_off_ext << 2);
  assign w_redirect = w_taken ? w_target : w_seq_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_redirect  <= '0;
      r_mis       <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_adv_out) begin
      r_out_valid <= w_s_valid;
      if (w_s_valid) begin
        r_taken    <= w_taken;
        r_target   <= w_target;
        r_redirect <= w_redirect;
        r_mis      <= (w_taken != w_s_pred);
      end
    end
  end

  // Counters see the handshake even in a flush cycle; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_count  <= '0;
      r_mis_count <= '0;
    end else if (r_out_valid && out_ready) begin
      if (r_br_count != '1) r_br_count <= r_br_count + CNT_W'(1);
      if (r_mis && (r_mis_count != '1)) r_mis_count <= r_mis_count + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign taken       = r_taken;
  assign target      = r_target;
  assign redirect_pc = r_redirect;
  assign mispredict  = r_mis;
  assign br_count    = r_br_count;
  assign mis_count   = r_mis_count;

endmodule
